alu_pipe: RTL
=============

# alu_pipe

Parametrised, pipelined integer ALU for the MIPS datapath. It accepts one operation per cycle through a valid/ready handshake and returns the result two cycles later. The result carries a passthrough tag and zero/carry/overflow/illegal flags. It replaces the single-cycle combinational ALU in the execute stage, and adds signed/unsigned compare, optional shifts, backpressure and a sticky overflow status.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥8
- `TAG_W`, 5: width of the passthrough tag (destination register index)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous assert, active-low; synchronous deassert is done outside this block
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  block can accept this cycle
- `in_op`  in  4  opcode (see Operation)
- `in_a`, `in_b`  in  WIDTH  operands
- `in_tag`  in  TAG_W  returned unchanged with the result
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `out_result`  out  WIDTH  result
- `out_tag`  out  TAG_W  tag of this result
- `out_zero`, `out_carry`, `out_ovf`, `out_illegal`  out  1 each  result flags
- `ovf_sticky`  out  1  set by any delivered result with `out_ovf`=1
- `ovf_clr`  in  1  synchronous clear of `ovf_sticky`

## Operation
- Opcodes:
  - 0 NOP → result 0
  - 1 ADD
  - 2 SUB
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOR
  - 7 SLT (signed a<b → 1, else 0)
  - 8 SLTU (unsigned a<b → 1, else 0)
  - 9 SLL
  - 10 SRL
  - 11 SRA
  - 12–15 illegal → result 0, `out_illegal`=1
- Arithmetic:
  - Modulo 2^WIDTH.
  - ADD carry = carry-out of bit WIDTH-1.
  - SUB carry = borrow, i.e. unsigned a<b.
  - Carry is 0 for all other ops.
- Overflow:
  - ADD: a[MSB]==b[MSB] and result[MSB]!=a[MSB].
  - SUB: a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
  - Overflow is 0 for all other ops.
  - Result is still written on overflow; no trap.
- Shifts:
  - Shift amount = b[log2(WIDTH)-1:0]; upper bits of b are ignored.
  - The value shifted is a.
  - SRA replicates a[MSB].
- Zero flag: `out_zero` = (result==0), for every op including NOP and illegal.
- Pipeline stages:
  - S1 registers op/operands/tag.
  - S2 registers result/flags/tag.
  - Each stage has its own valid bit.
- Stage advance:
  - S2 loads when `!s2_valid || out_ready`.
  - S1 advances into S2 under the same condition.
  - `in_ready` = `!s1_valid || !s2_valid || out_ready` (combinational path from `out_ready`).
- Transfers:
  - Input transfer = `in_valid && in_ready`.
  - Output transfer = `out_valid && out_ready`.
- `ovf_sticky`:
  - Set on an output transfer with `out_ovf`=1.
  - `ovf_clr` has priority over a simultaneous set.

## Timing
- Reset: all valid bits, `out_result`, `out_tag`, all flags and `ovf_sticky` are 0. `in_ready`=1 during and after reset.
- Latency: input transfer in cycle N → `out_valid` in cycle N+2 when not stalled.
- Throughput: 1 op/cycle with `out_ready` held high.
- Stall (`out_ready`=0 with S2 full):
  - S2 holds `out_result`/flags/tag stable.
  - S1 holds.
  - `in_ready` drops only once S1 is also full.
  - At most 2 ops are in flight.
- Simultaneous output transfer and S1 advance in the same cycle: no bubble, no loss.
- `out_valid` may not drop without a transfer. Output data may not change while `out_valid && !out_ready`.
- Reset mid-operation: in-flight ops are discarded; no output transfer follows from them.

## Configuration
- `ALU_PIPE_SHIFT_EN` defined: opcodes 9–11 are implemented as above.
- `ALU_PIPE_SHIFT_EN` undefined:
  - The shifter is removed.
  - Opcodes 9–11 decode as illegal (result 0, `out_illegal`=1, `out_zero`=1).
  - Timing and handshake are unchanged.

## Structure
- Shared package `alu_pkg` holds:
  - the 4-bit opcode type and named constants `OP_NOP` … `OP_SRA`;
  - a flags struct (zero, carry, ovf, illegal).
- One sub-module, `alu_core`: purely combinational; op/a/b in, result/flags out; instantiated between S1 and S2.
- Top level holds the handshake, stage registers and sticky logic.

## Test plan
- Reset release, then ADD a=32'h7FFFFFFF b=1 → 2 cycles later `out_result`=32'h80000000, `out_ovf`=1, `out_carry`=0; `ovf_sticky`=1 the cycle after the transfer.
- SUB a=3 b=5 → result 32'hFFFFFFFE, `out_carry`=1, `out_ovf`=0. SLT a=-1 b=1 → 1. SLTU a=-1 b=1 → 0.
- SRA a=32'h80000000 b=32'h0000_0104 → 32'hF8000000 (upper bits of b ignored). Without `ALU_PIPE_SHIFT_EN`: result 0, `out_illegal`=1.
- Back-to-back ops, tags 1..8, `out_ready`=1 → 8 consecutive results in order, no bubbles.
- Hold `out_ready`=0 while streaming → `in_ready` falls after 2 accepts and the output stays stable. Release → all ops delivered in order, none lost or duplicated.
- Opcode 13 → result 0, `out_illegal`=1, `out_zero`=1. Assert `ovf_clr` in the same cycle as an overflowing transfer → `ovf_sticky`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and result-flag struct shared by the pipelined ALU
package alu_pkg;
  typedef logic [3:0] op_t;
  localparam op_t OP_NOP  = 4'd0;
  localparam op_t OP_ADD  = 4'd1;
  localparam op_t OP_SUB  = 4'd2;
  localparam op_t OP_AND  = 4'd3;
  localparam op_t OP_OR   = 4'd4;
  localparam op_t OP_XOR  = 4'd5;
  localparam op_t OP_NOR  = 4'd6;
  localparam op_t OP_SLT  = 4'd7;
  localparam op_t OP_SLTU = 4'd8;
  localparam op_t OP_SLL  = 4'd9;
  localparam op_t OP_SRL  = 4'd10;
  localparam op_t OP_SRA  = 4'd11;
  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic illegal;
  } flags_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath; shifts exist only when ALU_PIPE_SHIFT_EN is defined
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output flags_t           flags_o
);
  localparam int M = WIDTH - 1;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
`ifdef ALU_PIPE_SHIFT_EN
  localparam int SH = $clog2(WIDTH);
  logic [SH-1:0] shamt;
  assign shamt = b_i[SH-1:0];
`endif
  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    diff     = {1'b0, a_i} - {1'b0, b_i};
    result_o = '0;
    flags_o  = '0;
    case (op_i)
      OP_NOP:  result_o = '0;
      OP_ADD: begin
        result_o      = sum[M:0];
        flags_o.carry = sum[WIDTH];
        flags_o.ovf   = (a_i[M] == b_i[M]) && (sum[M] != a_i[M]);
      end
      OP_SUB: begin
        result_o      = diff[M:0];
        flags_o.carry = diff[WIDTH];
        flags_o.ovf   = (a_i[M] != b_i[M]) && (diff[M] != a_i[M]);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_SLT:  result_o = {{M{1'b0}}, $signed(a_i) < $signed(b_i)};
      OP_SLTU: result_o = {{M{1'b0}}, diff[WIDTH]};
`ifdef ALU_PIPE_SHIFT_EN
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
`endif
      default: flags_o.illegal = 1'b1;
    endcase
    flags_o.zero = result_o == '0;
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshake and sticky overflow
// Optional shifter (opcodes 9-11) enabled by defining ALU_PIPE_SHIFT_EN.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);
  logic             s1_valid_q, s1_valid_d;
  op_t              s1_op_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, core_result;
  flags_t           s2_flags_q, core_flags;
  logic [TAG_W-1:0] s2_tag_q;
  logic             sticky_q, sticky_d;
  logic             advance, in_xfer, out_xfer;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op_i    (s1_op_q),
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .result_o(core_result),
    .flags_o (core_flags)
  );

  // S1 may refill in the same cycle it drains into S2, so a full pipe streams without bubbles
  always_comb begin
    advance    = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || advance;
    in_xfer    = in_valid && in_ready;
    out_xfer   = s2_valid_q && out_ready;
    s1_valid_d = in_xfer || (s1_valid_q && !advance);
    s2_valid_d = advance ? s1_valid_q : s2_valid_q;
    sticky_d   = !ovf_clr && (sticky_q || (out_xfer && s2_flags_q.ovf));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_NOP;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
      s2_tag_q    <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      sticky_q   <= sticky_d;
      if (in_xfer) begin
        s1_op_q  <= in_op;
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_tag_q <= in_tag;
      end
      if (advance && s1_valid_q) begin
        s2_result_q <= core_result;
        s2_flags_q  <= core_flags;
        s2_tag_q    <= s1_tag_q;
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_tag     = s2_tag_q;
  assign out_zero    = s2_flags_q.zero;
  assign out_carry   = s2_flags_q.carry;
  assign out_ovf     = s2_flags_q.ovf;
  assign out_illegal = s2_flags_q.illegal;
  assign ovf_sticky  = sticky_q;
endmodule
